// File: rtl/multicycle_control_unit.sv
// Multicycle CPU sequencing controller: a state register plus a combinational decode
// of the registered state, OpCode and Zero that drives every datapath control line.
module multicycle_control_unit (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] OpCode,
    input  logic       Zero,
    output logic [2:0] State,
    output logic       PCWre,
    output logic       IRWre,
    output logic       RegWre,
    output logic       RegDst,
    output logic       ALUSrcB,
    output logic       ExtSel,
    output logic [2:0] ALUOp,
    output logic       DataMemRW,
    output logic       DBDataSrc,
    output logic [1:0] PCSrc,
    output logic       Halted
);

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_t;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    state_t r_state;
    state_t w_next;

    logic w_is_rtype;
    logic w_is_imm;
    logic w_is_alu;
    logic w_is_sw;
    logic w_is_lw;
    logic w_is_beq;
    logic w_is_j;
    logic w_is_halt;
    logic w_is_undef;

    always_comb begin
        w_is_rtype = (OpCode == OP_ADD) || (OpCode == OP_SUB) || (OpCode == OP_OR) ||
                     (OpCode == OP_AND) || (OpCode == OP_SLT);
        w_is_imm   = (OpCode == OP_ADDI) || (OpCode == OP_ORI);
        w_is_alu   = w_is_rtype || w_is_imm;
        w_is_sw    = (OpCode == OP_SW);
        w_is_lw    = (OpCode == OP_LW);
        w_is_beq   = (OpCode == OP_BEQ);
        w_is_j     = (OpCode == OP_J);
        w_is_halt  = (OpCode == OP_HALT);
        w_is_undef = !(w_is_alu || w_is_sw || w_is_lw || w_is_beq || w_is_j || w_is_halt);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_IF;
        case (r_state)
            S_IF:     w_next = S_ID;
            S_ID: begin
                if (w_is_alu)                w_next = S_EXE_AL;
                else if (w_is_lw || w_is_sw) w_next = S_EXE_LS;
                else if (w_is_beq)           w_next = S_EXE_BR;
                else if (w_is_halt)          w_next = S_ID;
                else                         w_next = S_IF;
            end
            S_EXE_AL: w_next = S_WB_AL;
            S_WB_AL:  w_next = S_IF;
            S_EXE_LS: w_next = S_MEM;
            S_MEM:    w_next = w_is_lw ? S_WB_LD : S_IF;
            S_WB_LD:  w_next = S_IF;
            S_EXE_BR: w_next = S_IF;
            default:  w_next = S_IF;
        endcase
    end

    assign State = r_state;

    // Every control output is held low while Reset is high, so an abort writes nothing.
    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        RegDst    = 1'b0;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b0;
        ALUOp     = ALU_ADD;
        DataMemRW = 1'b0;
        DBDataSrc = 1'b0;
        PCSrc     = 2'b00;
        Halted    = 1'b0;
        if (!Reset) begin
            RegDst  = w_is_rtype;
            ALUSrcB = w_is_imm || w_is_lw || w_is_sw;
            ExtSel  = (OpCode != OP_ORI);
            case (OpCode)
                OP_SUB, OP_BEQ: ALUOp = ALU_SUB;
                OP_OR, OP_ORI:  ALUOp = ALU_OR;
                OP_AND:         ALUOp = ALU_AND;
                OP_SLT:         ALUOp = ALU_SLT;
                default:        ALUOp = ALU_ADD;
            endcase
            case (r_state)
                S_IF:     IRWre = 1'b1;
                S_ID: begin
                    PCWre  = w_is_j || w_is_undef;
                    PCSrc  = w_is_j ? 2'b10 : 2'b00;
                    Halted = w_is_halt;
                end
                S_MEM: begin
                    PCWre     = w_is_sw;
                    DataMemRW = w_is_sw;
                end
                S_WB_LD: begin
                    PCWre     = 1'b1;
                    RegWre    = 1'b1;
                    DBDataSrc = 1'b1;
                end
                S_EXE_BR: begin
                    PCWre = 1'b1;
                    PCSrc = Zero ? 2'b01 : 2'b00;
                end
                S_WB_AL: begin
                    PCWre  = 1'b1;
                    RegWre = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed and random instruction streams compared
// each cycle against a per-instruction-class sequence model.
module tb_multicycle_control_unit;

    logic       CLK;
    logic       Reset;
    logic [5:0] OpCode;
    logic       Zero;
    logic [2:0] State;
    logic       PCWre, IRWre, RegWre, RegDst, ALUSrcB, ExtSel;
    logic [2:0] ALUOp;
    logic       DataMemRW, DBDataSrc;
    logic [1:0] PCSrc;
    logic       Halted;
    logic [16:0] w_obs;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    multicycle_control_unit dut (
        .CLK(CLK), .Reset(Reset), .OpCode(OpCode), .Zero(Zero), .State(State),
        .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .RegDst(RegDst),
        .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUOp(ALUOp), .DataMemRW(DataMemRW),
        .DBDataSrc(DBDataSrc), .PCSrc(PCSrc), .Halted(Halted)
    );

    assign w_obs = {State, PCWre, IRWre, RegWre, RegDst, ALUSrcB, ExtSel, ALUOp,
                    DataMemRW, DBDataSrc, PCSrc, Halted};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_vec(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (state pcw irw rgw dst srcb ext aluop dmw dbs pcsrc hlt)",
                     tag, got, exp);
        end
    endtask

    // Instruction classes: 0 alu, 1 lw, 2 sw, 3 beq, 4 j, 5 undefined, 6 halt
    function automatic int op_class(input logic [5:0] op);
        case (op)
            6'b000000, 6'b000001, 6'b000010, 6'b010000,
            6'b010001, 6'b010010, 6'b100110: return 0;
            6'b110001: return 1;
            6'b110000: return 2;
            6'b110100: return 3;
            6'b111000: return 4;
            6'b111111: return 6;
            default:   return 5;
        endcase
    endfunction

    function automatic int class_len(input int cls);
        case (cls)
            0: return 4;
            1: return 5;
            2: return 4;
            3: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [2:0] seq_state(input int cls, input int step);
        logic [2:0] alu_seq [4] = '{3'd0, 3'd1, 3'd6, 3'd7};
        logic [2:0] ls_seq  [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        logic [2:0] br_seq  [3] = '{3'd0, 3'd1, 3'd5};
        case (cls)
            0:       return alu_seq[step];
            1, 2:    return ls_seq[step];
            3:       return br_seq[step];
            default: return (step == 0) ? 3'd0 : 3'd1;
        endcase
    endfunction

    function automatic logic [16:0] model(input logic [5:0] op, input int step, input logic z);
        int   cls  = op_class(op);
        logic last = (cls != 6) && (step == class_len(cls) - 1);
        logic [2:0] aop;
        logic [1:0] psrc;
        logic dst, srcb, ext;
        case (op)
            6'b000001, 6'b110100: aop = 3'b001;
            6'b010000, 6'b010010: aop = 3'b010;
            6'b010001:            aop = 3'b011;
            6'b100110:            aop = 3'b100;
            default:              aop = 3'b000;
        endcase
        dst  = (op == 6'b000000) || (op == 6'b000001) || (op == 6'b010000) ||
               (op == 6'b010001) || (op == 6'b100110);
        srcb = (op == 6'b000010) || (op == 6'b010010) || (op == 6'b110001) || (op == 6'b110000);
        ext  = (op != 6'b010010);
        psrc = (last && cls == 4) ? 2'b10 : (last && cls == 3 && z) ? 2'b01 : 2'b00;
        return {seq_state(cls, step), last, step == 0, last && (cls == 0 || cls == 1),
                dst, srcb, ext, aop, last && cls == 2, last && cls == 1, psrc,
                (cls == 6) && (step >= 1)};
    endfunction

    // Called at posedge+1; leaves time at posedge+1 of the cycle after the instruction.
    task automatic run_instr(input logic [5:0] op, input int zmode, input int halt_cycles);
        int cls = op_class(op);
        int n   = (cls == 6) ? halt_cycles : class_len(cls);
        OpCode = op;
        for (int i = 0; i < n; i++) begin
            Zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
            #1 check_vec($sformatf("op%b_step%0d", op, i), w_obs, model(op, i, Zero));
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        logic [5:0] ops [11] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                                6'b010010, 6'b100110, 6'b110000, 6'b110001, 6'b110100,
                                6'b111000};
        logic [5:0] op;
        Reset  = 1'b1;
        OpCode = '0;
        Zero   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK);
            #1 check_vec("reset", w_obs, 17'b0);
        end
        Reset = 1'b0;

        run_instr(6'b000000, 2, 0);
        run_instr(6'b110001, 2, 0);
        run_instr(6'b110000, 2, 0);
        run_instr(6'b110100, 1, 0);
        run_instr(6'b110100, 0, 0);
        run_instr(6'b111000, 2, 0);
        run_instr(6'b010010, 2, 0);
        run_instr(6'b101010, 2, 0);

        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                op = 6'($urandom);
                if (op == 6'b111111) op = 6'b101010;
            end else begin
                op = ops[$urandom_range(0, 10)];
            end
            run_instr(op, 2, 0);
        end

        run_instr(6'b111111, 2, 12);
        Reset = 1'b1;
        #1 check_vec("halt_reset_assert", w_obs, {3'b001, 14'b0});
        @(posedge CLK);
        #1 check_vec("halt_reset_edge", w_obs, 17'b0);
        Reset = 1'b0;

        OpCode = 6'b110001;
        for (int i = 0; i < 3; i++) begin
            Zero = 1'($urandom_range(0, 1));
            #1 check_vec($sformatf("lw_abort_step%0d", i), w_obs, model(6'b110001, i, Zero));
            @(posedge CLK);
            #1;
        end
        Reset = 1'b1;
        #1 check_vec("lw_mem_reset", w_obs, {3'b011, 14'b0});
        @(posedge CLK);
        #1 check_vec("lw_abort_edge", w_obs, 17'b0);
        Reset = 1'b0;
        run_instr(6'b110001, 2, 0);
        run_instr(6'b000001, 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
